countdown_timer: RTL and testbench

- Loadable, prescaled down-counter; the counting-down counterpart of the team's free-running up-counter.
- Software or a sequencer loads a start value through a valid/ready handshake, then starts, pauses or aborts it.
- Emits a one-cycle terminal-count pulse when the count expires, with an optional auto-reload (periodic) mode.
- Used as the timeout and periodic-tick source for neighbouring blocks.

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/countdown_timer.sv | 130 +++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default widths.
package counter_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_PRESC_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for the countdown timer: a down-counter that emits a tick on the
// enabled cycle where it sits at zero, then restarts from the reload value.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               set,
    input  logic [PRESC_W-1:0] set_val,
    input  logic               enable,
    input  logic [PRESC_W-1:0] reload_val,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_reg;

    assign tick = enable && (presc_cnt_reg == '0);

    // clear beats set beats counting, matching the timer's abort > load/start > run order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_reg <= '0;
        end else if (clear) begin
            presc_cnt_reg <= '0;
        end else if (set) begin
            presc_cnt_reg <= set_val;
        end else if (enable) begin
            if (tick) begin
                presc_cnt_reg <= reload_val;
            end else begin
                presc_cnt_reg <= presc_cnt_reg - PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with one-cycle terminal-count pulse and
// optional auto-reload; used as a timeout / periodic-tick source.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [PRESC_W-1:0] load_presc,
    input  logic               load_auto,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   cnt,
    output logic               busy,
    output logic               tc
);

    timer_state_e       state_reg, state_next;
    logic [WIDTH-1:0]   cnt_reg;
    logic [WIDTH-1:0]   reload_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic               auto_reg;
    logic               tc_reg;

    logic               load_fire;
    logic               restart;
    logic               counting;
    logic               tick;
    logic               last_tick;
    logic               presc_set;
    logic [PRESC_W-1:0] presc_set_val;

    // abort > load > start > pause: each lower-priority action is masked by the ones above it
    assign load_fire = load_valid && load_ready && !abort;
    assign restart   = start && !abort && !load_fire && (state_reg == DONE);
    assign counting  = !abort && !load_fire && (state_reg == RUN) && !pause;
    assign last_tick = tick && (cnt_reg == WIDTH'(1));

    assign presc_set     = load_fire || restart;
    assign presc_set_val = load_fire ? load_presc : presc_reg;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (abort),
        .set        (presc_set),
        .set_val    (presc_set_val),
        .enable     (counting),
        .reload_val (presc_reg),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else if (load_fire) begin
            state_next = ARMED;
        end else begin
            case (state_reg)
                ARMED:   if (start) state_next = RUN;
                DONE:    if (start) state_next = RUN;
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (last_tick && !auto_reg) begin
                        state_next = DONE;
                    end
                end
                PAUSED:  if (!pause) state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        busy       = (state_reg == RUN) || (state_reg == PAUSED);
        load_ready = (state_reg == IDLE) || (state_reg == ARMED) || (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            reload_reg <= '0;
            presc_reg  <= '0;
            auto_reg   <= 1'b0;
            tc_reg     <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (abort) begin
                cnt_reg <= '0;
            end else if (load_fire) begin
                cnt_reg    <= load_value;
                reload_reg <= load_value;
                presc_reg  <= load_presc;
                auto_reg   <= load_auto;
            end else if (restart) begin
                cnt_reg <= reload_reg;
            end else if (tick) begin
                if (last_tick) begin
                    cnt_reg <= auto_reg ? reload_reg : '0;
                    tc_reg  <= 1'b1;
                end else begin
                    // a zero load counts through the all-ones wrap, giving 2^WIDTH ticks
                    cnt_reg <= cnt_reg - WIDTH'(1);
                end
            end
        end
    end

    assign cnt = cnt_reg;
    assign tc  = tc_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, hand sequences and
// randomized trials predicted from tick arithmetic.
module tb_countdown_timer;

    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;

    logic               clk;
    logic               rst_n;
    logic               load_valid;
    logic               load_ready;
    logic [WIDTH-1:0]   load_value;
    logic [PRESC_W-1:0] load_presc;
    logic               load_auto;
    logic               start;
    logic               pause;
    logic               abort;
    logic [WIDTH-1:0]   cnt;
    logic               busy;
    logic               tc;

    int checks;
    int failures;

    countdown_timer #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_presc (load_presc),
        .load_auto  (load_auto),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .cnt        (cnt),
        .busy       (busy),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [15:0] val;
        logic [7:0]  presc;
        logic        au;
        logic        st;
        logic        pa;
        logic        ab;
        logic [15:0] e_cnt;
        logic        e_busy;
        logic        e_tc;
        logic        e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic lv, logic [15:0] val, logic [7:0] presc, logic au,
                                logic st, logic pa, logic ab, logic [15:0] e_cnt,
                                logic e_busy, logic e_tc, logic e_ready);
        vec_t v;
        v.lv = lv; v.val = val; v.presc = presc; v.au = au;
        v.st = st; v.pa = pa; v.ab = ab;
        v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_tc = e_tc; v.e_ready = e_ready;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0; load_value = '0; load_presc = '0; load_auto = 1'b0;
        start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    // Predicts cnt/tc/busy from elapsed edges: every edge after start is a
    // counting edge except the pause edges and the one resume edge after them.
    task automatic run_trial(input int v, input int p, input int d, input int k, input string tag);
        logic [31:0] vv;
        int total, lost, a, ticks, exp_cnt, n_tc;
        vv = v;
        total = v * (p + 1);
        n_tc = 0;
        load_valid = 1'b1; load_value = vv[15:0]; load_presc = p[7:0]; load_auto = 1'b0;
        step();
        load_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_start_cnt"}, cnt, vv[15:0]);
        for (int t = 1; t <= total + k + 3; t++) begin
            pause = (k > 0) && (t >= d) && (t < d + k);
            step();
            lost = 0;
            if (k > 0 && t >= d) lost = (t >= d + k) ? k + 1 : t - d + 1;
            a = t - lost;
            ticks = a / (p + 1);
            if (ticks > v) ticks = v;
            exp_cnt = (v - ticks) & 32'hFFFF;
            if (tc === 1'b1) n_tc++;
            if (total > 1000) begin
                // long runs: check the boundary edges only, keep output short
                if (t == 1 || t >= total - 1) begin
                    chk({tag, "_cnt"}, cnt, exp_cnt);
                    chk({tag, "_tc"}, tc, (a == total) ? 1 : 0);
                end
            end else begin
                chk({tag, "_cnt"}, cnt, exp_cnt);
                chk({tag, "_tc"}, tc, (a == total) ? 1 : 0);
                chk({tag, "_busy"}, busy, (ticks < v) ? 1 : 0);
            end
        end
        pause = 1'b0;
        chk({tag, "_tc_pulses"}, n_tc, 1);
        chk({tag, "_done_ready"}, load_ready, 1);
        $display("trial %s: V=%0d P=%0d pause_at=%0d len=%0d expiry_edge=%0d", tag, v, p, d, k,
                 total + ((k > 0) ? k + 1 : 0));
    endtask

    initial begin
        int v, p, d, k, tc_seen;
        checks = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tc", tc, 0);
        chk("rst_ready", load_ready, 1);
        rst_n = 1'b1;
        step();

        //          lv  val presc au st pa ab   cnt busy tc rdy
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0,    5, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,    5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,    5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 1));
        tbl.push_back(mk(1, 9, 1, 0, 1, 0, 0,    9, 0, 0, 1));
        tbl.push_back(mk(1, 7, 0, 0, 1, 0, 0,    7, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,    7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,    7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0,    5, 1, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 1,    0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 1));
        tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0,    2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,    2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 1));

        foreach (tbl[i]) begin
            load_valid = tbl[i].lv; load_value = tbl[i].val; load_presc = tbl[i].presc;
            load_auto = tbl[i].au; start = tbl[i].st; pause = tbl[i].pa; abort = tbl[i].ab;
            step();
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].e_cnt);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_tc", i), tc, tbl[i].e_tc);
            chk($sformatf("vec%0d_ready", i), load_ready, tbl[i].e_ready);
            $display("vec %0d: cnt=%0d busy=%0b tc=%0b ready=%0b", i, cnt, busy, tc, load_ready);
        end
        idle_inputs();

        // auto-reload period 4 for three periods, then abort silences it
        load_valid = 1'b1; load_value = 16'd4; load_auto = 1'b1;
        step();
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            step();
            chk("auto_cnt", cnt, (t % 4 == 0) ? 4 : 4 - (t % 4));
            chk("auto_tc", tc, (t % 4 == 0) ? 1 : 0);
        end
        $display("auto-reload: three periods of 4 observed");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("auto_abort_cnt", cnt, 0);
        chk("auto_abort_busy", busy, 0);
        tc_seen = 0;
        repeat (6) begin
            step();
            if (tc !== 1'b0) tc_seen++;
        end
        chk("auto_abort_no_tc", tc_seen, 0);

        run_trial(3, 2, 0, 0, "presc");
        run_trial(10, 0, 5, 3, "pause");

        for (int n = 0; n < 20; n++) begin
            v = $urandom_range(1, 12);
            p = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            d = 1;
            if (v * (p + 1) > 1) d = $urandom_range(1, v * (p + 1) - 1);
            else k = 0;
            run_trial(v, p, d, k, $sformatf("rnd%0d", n));
        end

        run_trial(65536, 0, 0, 0, "wrap");

        // asynchronous reset in the middle of a run, away from any clock edge
        load_valid = 1'b1; load_value = 16'd20; load_presc = '0;
        step();
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        chk("areset_pre_cnt", cnt, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_cnt", cnt, 0);
        chk("areset_busy", busy, 0);
        chk("areset_tc", tc, 0);
        chk("areset_ready", load_ready, 1);
        step();
        rst_n = 1'b1;
        tc_seen = 0;
        repeat (8) begin
            step();
            if (tc !== 1'b0 || busy !== 1'b0) tc_seen++;
        end
        chk("areset_quiet", tc_seen, 0);
        $display("async reset: outputs cleared mid-cycle at cnt=7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
